// File: rtl/hyperram_pkg.sv
// hyperram_pkg: shared FSM encodings and constants for the HyperRAM Wishbone arbiter.
package hyperram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [31:0] DEAD_BEEF   = 32'hDEAD_BEEF;
    localparam int          TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: stall counter that fires when a granted transfer waits too long for ack.
//   clk, rst : clock and synchronous active-high reset
//   active   : a master currently holds the grant
//   stall    : strobe asserted without ack this cycle
//   ack      : slave ack this cycle (restarts the count)
//   fire     : limit reached; fabricate an ack and abort
module wb_arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stall,
    input  logic ack,
    output logic fire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Held at zero while idle, so every new grant starts from a clean count.
    always_ff @(posedge clk) begin
        if (rst || !active || ack)
            cnt <= '0;
        else if (stall)
            cnt <= cnt + 1'b1;
    end

    assign fire = active && (cnt == CW'(LIMIT));

endmodule

// File: rtl/wb_hyperram_arbiter.sv
// wb_hyperram_arbiter: round-robin two-master to one-slave Wishbone arbiter in front of wb_hyperram.
//   wb_clk_i, wb_rst_i : clock and synchronous active-high reset
//   m0_* / m1_*        : master ports (m0 = management bus, m1 = user-side requester)
//   s_*                : slave port toward wb_hyperram
//   grant_o            : one-hot {m1,m0} grant, 00 when idle
//   timeout_o          : sticky watchdog flag, present only when WB_ARB_TIMEOUT_EN is defined
module wb_hyperram_arbiter
    import hyperram_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef WB_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic [DW-1:0]   m1_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,
    output logic [1:0]      grant_o
`ifdef WB_ARB_TIMEOUT_EN
    , output logic          timeout_o
`endif
);

    state_t state, state_nx;
    logic   last, last_nx;
    logic   g0, g1, fire;
    logic   req0, req1;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign g0      = (state == ST_GNT0);
    assign g1      = (state == ST_GNT1);
    assign grant_o = {g1, g0};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            last  <= last_nx;
        end
    end

    // Grants always return through IDLE, so the slave sees cyc low between masters.
    always_comb begin
        state_nx = state;
        last_nx  = last;
        case (state)
            ST_IDLE: begin
                if (req0 && (!req1 || last))
                    state_nx = ST_GNT0;
                else if (req1)
                    state_nx = ST_GNT1;
            end
            ST_GNT0: begin
                if (!m0_cyc_i || fire) begin
                    state_nx = ST_IDLE;
                    last_nx  = 1'b0;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i || fire) begin
                    state_nx = ST_IDLE;
                    last_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Slave-side mux depends only on state and master inputs; fire is registered-count based.
    assign s_cyc_o = ~fire & (g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0);
    assign s_stb_o = ~fire & (g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0);
    assign s_we_o  = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
    assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;

    assign m0_ack_o = g0 & (s_ack_i | fire);
    assign m1_ack_o = g1 & (s_ack_i | fire);
    assign m0_dat_o = g0 ? (fire ? DW'(DEAD_BEEF) : s_dat_i) : '0;
    assign m1_dat_o = g1 ? (fire ? DW'(DEAD_BEEF) : s_dat_i) : '0;

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .active (g0 | g1),
        .stall  (s_stb_o & ~s_ack_i),
        .ack    (s_ack_i),
        .fire   (fire)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            timeout_o <= 1'b0;
        else if (fire)
            timeout_o <= 1'b1;
    end
`else
    assign fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_hyperram_arbiter.sv
// tb_wb_hyperram_arbiter: directed self-checking bench for the round-robin Wishbone arbiter.
module tb_wb_hyperram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdat, m1_rdat;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr, s_wdat, s_dat;
    logic [1:0]  grant;
    logic        timeout;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    wb_hyperram_arbiter #(
        .AW(32), .DW(32)
`ifdef WB_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_dat),
        .grant_o(grant)
`ifdef WB_ARB_TIMEOUT_EN
        , .timeout_o(timeout)
`endif
    );

`ifndef WB_ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
        {m0_sel, m1_sel} = '0;
        {m0_adr, m0_dat, m1_adr, m1_dat, s_dat} = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_cyc", s_cyc, 0);
        chk("rst_stb", s_stb, 0);
        chk("rst_adr", s_adr, 0);
        chk("rst_ack0", m0_ack, 0);
        chk("rst_ack1", m1_ack, 0);
        chk("rst_timeout", timeout, 0);

        // single m0 read with a three-cycle slave latency
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0004; m0_sel = 4'hf;
        #1;
        chk("t1_latency_cyc", s_cyc, 0);
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_cyc", s_cyc, 1);
        chk("t1_adr", s_adr, 32'h3000_0004);
        chk("t1_sel", s_sel, 4'hf);
        chk("t1_we", s_we, 0);
        tick();
        tick();
        chk("t1_noack_yet", m0_ack, 0);
        s_ack = 1; s_dat = 32'h1234_5678;
        #1;
        chk("t1_ack0", m0_ack, 1);
        chk("t1_dat0", m0_rdat, 32'h1234_5678);
        chk("t1_ack1", m1_ack, 0);
        chk("t1_dat1", m1_rdat, 0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        chk("t1_cyc_drop", s_cyc, 0);
        tick();
        chk("t1_idle", grant, 2'b00);

        // simultaneous requests right after reset: m0 first
        rst = 1;
        tick();
        rst = 0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0040;
        tick();
        chk("t2_first_m0", grant, 2'b01);
        chk("t2_adr_m0", s_adr, 32'h3000_0004);
        s_ack = 1; s_dat = 32'h0000_00aa;
        #1;
        chk("t2_ack0", m0_ack, 1);
        chk("t2_ack1_blocked", m1_ack, 0);
        chk("t2_dat1_blocked", m1_rdat, 0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        chk("t2_gap_grant", grant, 2'b00);
        chk("t2_gap_cyc", s_cyc, 0);
        tick();
        chk("t2_then_m1", grant, 2'b10);
        chk("t2_adr_m1", s_adr, 32'h0000_0040);
        m1_cyc = 0; m1_stb = 0;
        tick();
        chk("t2_idle", grant, 2'b00);
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("t2_rr_m0_again", grant, 2'b01);
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("t2_idle2", grant, 2'b00);

        // m1 burst of four write beats while m0 waits
        m1_we = 1; m1_sel = 4'h3; m0_cyc = 1; m0_stb = 1;
        tick();
        chk("t3_grant_m1", grant, 2'b10);
        for (int i = 1; i <= 4; i++) begin
            m1_dat = i; s_ack = 1;
            #1;
            chk("t3_beat_dat", s_wdat, i);
            chk("t3_beat_we", s_we, 1);
            chk("t3_beat_ack1", m1_ack, 1);
            chk("t3_beat_ack0", m0_ack, 0);
            chk("t3_beat_grant", grant, 2'b10);
            tick();
        end
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        tick();
        chk("t3_gap", grant, 2'b00);
        chk("t3_gap_cyc", s_cyc, 0);
        tick();
        chk("t3_m0_after", grant, 2'b01);
        m0_cyc = 0; m0_stb = 0;
        tick();

        // reset during GNT1 with an ack still outstanding
        m1_cyc = 1; m1_stb = 1;
        tick();
        chk("t4_grant_m1", grant, 2'b10);
        rst = 1;
        tick();
        rst = 0;
        chk("t4_rst_cyc", s_cyc, 0);
        chk("t4_rst_grant", grant, 2'b00);
        s_ack = 1;
        #1;
        chk("t4_late_ack1", m1_ack, 0);
        chk("t4_late_ack0", m0_ack, 0);
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        tick();

        // m0 abandons its cycle; stray ack in IDLE; m1 served next
        m0_cyc = 1; m0_stb = 1;
        tick();
        chk("t5_grant_m0", grant, 2'b01);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1;
        #1;
        chk("t5_drop_cyc", s_cyc, 0);
        tick();
        chk("t5_idle", grant, 2'b00);
        s_ack = 1;
        #1;
        chk("t5_stray_ack0", m0_ack, 0);
        chk("t5_stray_ack1", m1_ack, 0);
        chk("t5_stray_cyc", s_cyc, 0);
        tick();
        s_ack = 0;
        #1;
        chk("t5_grant_m1", grant, 2'b10);
        chk("t5_cyc_m1", s_cyc, 1);
        m1_cyc = 0; m1_stb = 0;
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // slave never acks: watchdog fabricates the ack after eight stalled cycles
        m0_cyc = 1; m0_stb = 1;
        tick();
        chk("t6_grant", grant, 2'b01);
        for (int i = 0; i < 8; i++) begin
            chk("t6_no_ack_yet", m0_ack, 0);
            tick();
        end
        chk("t6_fake_ack", m0_ack, 1);
        chk("t6_fake_dat", m0_rdat, 32'hDEAD_BEEF);
        chk("t6_cyc_forced", s_cyc, 0);
        chk("t6_stb_forced", s_stb, 0);
        chk("t6_flag_not_yet", timeout, 0);
        tick();
        chk("t6_idle", grant, 2'b00);
        chk("t6_flag", timeout, 1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("t6_m1_grant", grant, 2'b10);
        s_ack = 1; s_dat = 32'h0000_0055;
        #1;
        chk("t6_m1_ack", m1_ack, 1);
        chk("t6_m1_dat", m1_rdat, 32'h0000_0055);
        chk("t6_flag_sticky", timeout, 1);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
